// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access with byte/half/word alignment,
// load extension, MEM/WB register and load-response stall control.

package mem_stage_pkg;
  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [2:0] mem_size;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           rs2_data_str;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    ctrl_t                     ctrl;
    logic                      valid_ex_mem;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           load_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    ctrl_t                     ctrl;
    logic                      valid_mem_wb;
  } mem_wb_reg_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  ex_mem_reg_t               ex_mem_in,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_ready,
  input  logic                      dmem_rvalid,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic [XLEN-1:0]           mem_alu_result,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                      mem_reg_write,
  output logic                      stall_mem,
  output logic                      misaligned,
  output logic                      bus_error,
  output mem_wb_reg_t               mem_wb_out
);

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, WAIT_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         size_q, size_d;
  mem_wb_reg_t        mem_wb_q, mem_wb_d;

  logic               op;
  logic [1:0]         off;
  logic [1:0]         sz;
  logic               mis;
  logic [3:0]         be_base;
  logic [XLEN-1:0]    rd_shifted;
  logic [XLEN-1:0]    load_ext;
  logic [CNT_W-1:0]   cnt_next;
  logic               timeout;
  mem_wb_reg_t        wb_fill;

  assign op        = ex_mem_in.valid_ex_mem & (ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write);
  assign off       = ex_mem_in.alu_result[1:0];
  assign sz        = ex_mem_in.ctrl.mem_size[1:0];
  assign mis       = ((sz == 2'b01) & off[0]) | ((sz == 2'b10) & (off != 2'b00));
  assign dmem_addr = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};

  assign mem_alu_result = ex_mem_in.alu_result;
  assign mem_rd_addr    = ex_mem_in.rd_addr;
  assign mem_reg_write  = ex_mem_in.valid_ex_mem & ex_mem_in.ctrl.reg_write & ~ex_mem_in.ctrl.mem_read;
  assign mem_wb_out     = mem_wb_q;

  assign cnt_next = wait_cnt_q + 1'b1;
  assign timeout  = (WAIT_TIMEOUT != 0) && (cnt_next == CNT_W'(WAIT_TIMEOUT));

  // Lane extraction uses the offset/size captured at accept time, since the
  // address bits on ex_mem_in are not guaranteed stable during the wait.
  always_comb begin
    rd_shifted = dmem_rdata >> {off_q, 3'b000};
    case (size_q)
      3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_ext = {24'b0, rd_shifted[7:0]};
      3'b101:  load_ext = {16'b0, rd_shifted[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    case (sz)
      2'b00:   begin be_base = 4'b0001; dmem_wdata = {4{ex_mem_in.rs2_data_str[7:0]}};  end
      2'b01:   begin be_base = 4'b0011; dmem_wdata = {2{ex_mem_in.rs2_data_str[15:0]}}; end
      default: begin be_base = 4'b1111; dmem_wdata = ex_mem_in.rs2_data_str;            end
    endcase
    dmem_be = (sz == 2'b10 || sz == 2'b11) ? 4'b1111 : 4'(be_base << off);
  end

  always_comb begin
    wb_fill              = '0;
    wb_fill.alu_result   = ex_mem_in.alu_result;
    wb_fill.rd_addr      = ex_mem_in.rd_addr;
    wb_fill.ctrl         = ex_mem_in.ctrl;
    wb_fill.valid_mem_wb = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    off_d      = off_q;
    size_d     = size_q;
    mem_wb_d   = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    stall_mem  = 1'b0;
    misaligned = 1'b0;
    bus_error  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!op) begin
          mem_wb_d              = wb_fill;
          mem_wb_d.valid_mem_wb = ex_mem_in.valid_ex_mem;
        end else if (mis) begin
          misaligned              = 1'b1;
          mem_wb_d                = wb_fill;
          mem_wb_d.ctrl.reg_write = 1'b0;
        end else if (ex_mem_in.ctrl.mem_write) begin
          dmem_req  = 1'b1;
          dmem_we   = 1'b1;
          stall_mem = ~dmem_ready;
          if (dmem_ready) mem_wb_d = wb_fill;
        end else begin
          dmem_req  = 1'b1;
          stall_mem = 1'b1;
          if (dmem_ready) begin
            off_d   = off;
            size_d  = ex_mem_in.ctrl.mem_size;
            state_d = WAIT_RESP;
          end
        end
      end

      WAIT_RESP: begin
        if (dmem_rvalid) begin
          mem_wb_d           = wb_fill;
          mem_wb_d.load_data = load_ext;
          state_d            = IDLE;
        end else if (timeout) begin
          bus_error               = 1'b1;
          mem_wb_d                = wb_fill;
          mem_wb_d.ctrl.reg_write = 1'b0;
          state_d                 = IDLE;
        end else begin
          stall_mem  = 1'b1;
          wait_cnt_d = cnt_next;
        end
      end

      default: state_d = IDLE;
    endcase

    // Keep the bus and pipeline quiet while reset is held.
    if (reset) begin
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      stall_mem  = 1'b0;
      misaligned = 1'b0;
      bus_error  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      off_q      <= '0;
      size_q     <= '0;
      mem_wb_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      mem_wb_q   <= mem_wb_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: stores, loads with extension,
// misalignment, forwarding, timeout and reset during an outstanding load.

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                      clk;
  logic                      reset;
  ex_mem_reg_t               ex_mem_in;
  logic                      dmem_req;
  logic                      dmem_we;
  logic [XLEN-1:0]           dmem_addr;
  logic [XLEN-1:0]           dmem_wdata;
  logic [3:0]                dmem_be;
  logic                      dmem_ready;
  logic                      dmem_rvalid;
  logic [XLEN-1:0]           dmem_rdata;
  logic [XLEN-1:0]           mem_alu_result;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
  logic                      mem_reg_write;
  logic                      stall_mem;
  logic                      misaligned;
  logic                      bus_error;
  mem_wb_reg_t               mem_wb_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.WAIT_TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_mem_in      (ex_mem_in),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ready     (dmem_ready),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .mem_alu_result (mem_alu_result),
    .mem_rd_addr    (mem_rd_addr),
    .mem_reg_write  (mem_reg_write),
    .stall_mem      (stall_mem),
    .misaligned     (misaligned),
    .bus_error      (bus_error),
    .mem_wb_out     (mem_wb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled around the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic rd_mem,
                               input logic wr_mem, input logic reg_wr,
                               input logic [2:0] size, input logic valid);
    ex_mem_in.alu_result     = addr;
    ex_mem_in.rs2_data_str   = rs2;
    ex_mem_in.rd_addr        = rd;
    ex_mem_in.ctrl.mem_read  = rd_mem;
    ex_mem_in.ctrl.mem_write = wr_mem;
    ex_mem_in.ctrl.reg_write = reg_wr;
    ex_mem_in.ctrl.mem_size  = size;
    ex_mem_in.valid_ex_mem   = valid;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd0);
    checkOutput("reset_stall",    32'(stall_mem), 32'd0);
    checkOutput("reset_req",      32'(dmem_req), 32'd0);

    // SW 0x100, immediate ready
    dmem_ready = 1'b1;
    applyStimulus(32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1);
    checkOutput("sw_req",   32'(dmem_req), 32'd1);
    checkOutput("sw_we",    32'(dmem_we), 32'd1);
    checkOutput("sw_be",    32'(dmem_be), 32'hF);
    checkOutput("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    checkOutput("sw_addr",  dmem_addr, 32'h100);
    checkOutput("sw_stall", 32'(stall_mem), 32'd0);
    tick();
    checkOutput("sw_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd1);
    checkOutput("sw_wb_alu",   mem_wb_out.alu_result, 32'h100);

    // SB 0x103, ready delayed two cycles
    dmem_ready = 1'b0;
    applyStimulus(32'h103, 32'h000000A5, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    checkOutput("sb_be",     32'(dmem_be), 32'h8);
    checkOutput("sb_wdata",  dmem_wdata, 32'hA5A5A5A5);
    checkOutput("sb_addr",   dmem_addr, 32'h100);
    checkOutput("sb_stall1", 32'(stall_mem), 32'd1);
    tick();
    checkOutput("sb_bubble", 32'(mem_wb_out.valid_mem_wb), 32'd0);
    checkOutput("sb_stall2", 32'(stall_mem), 32'd1);
    tick();
    dmem_ready = 1'b1;
    #1;
    checkOutput("sb_stall_done", 32'(stall_mem), 32'd0);
    tick();
    checkOutput("sb_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd1);
    checkOutput("sb_wb_alu",   mem_wb_out.alu_result, 32'h103);

    // LB 0x202, rvalid on the third wait cycle
    applyStimulus(32'h202, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1);
    checkOutput("lb_req",   32'(dmem_req), 32'd1);
    checkOutput("lb_we",    32'(dmem_we), 32'd0);
    checkOutput("lb_be",    32'(dmem_be), 32'h4);
    checkOutput("lb_stall", 32'(stall_mem), 32'd1);
    checkOutput("lb_fwd_rw", 32'(mem_reg_write), 32'd0);
    tick();
    dmem_ready = 1'b0;
    #1;
    checkOutput("lb_wait_req",   32'(dmem_req), 32'd0);
    checkOutput("lb_wait_stall", 32'(stall_mem), 32'd1);
    checkOutput("lb_wait_wb",    32'(mem_wb_out.valid_mem_wb), 32'd0);
    tick();
    checkOutput("lb_wait2_stall", 32'(stall_mem), 32'd1);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0080_0000;
    #1;
    checkOutput("lb_rvalid_stall", 32'(stall_mem), 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("lb_data",     mem_wb_out.load_data, 32'hFFFFFF80);
    checkOutput("lb_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd1);
    checkOutput("lb_wb_rd",    32'(mem_wb_out.rd_addr), 32'd5);

    // LBU of the same word, response right after accept
    dmem_ready = 1'b1;
    applyStimulus(32'h202, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b100, 1'b1);
    tick();
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b1;
    #1;
    checkOutput("lbu_stall", 32'(stall_mem), 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("lbu_data", mem_wb_out.load_data, 32'h00000080);

    // LH 0x201 is misaligned
    dmem_ready = 1'b1;
    applyStimulus(32'h201, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1);
    checkOutput("lh_mis",   32'(misaligned), 32'd1);
    checkOutput("lh_req",   32'(dmem_req), 32'd0);
    checkOutput("lh_stall", 32'(stall_mem), 32'd0);
    tick();
    checkOutput("lh_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd1);
    checkOutput("lh_wb_rw",    32'(mem_wb_out.ctrl.reg_write), 32'd0);

    // ADD forwarding
    applyStimulus(32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
    checkOutput("add_mis",   32'(misaligned), 32'd0);
    checkOutput("add_fwd_rw", 32'(mem_reg_write), 32'd1);
    checkOutput("add_fwd_res", mem_alu_result, 32'h1234);
    checkOutput("add_fwd_rd",  32'(mem_rd_addr), 32'd7);
    checkOutput("add_req",     32'(dmem_req), 32'd0);
    tick();
    checkOutput("add_wb_rw",   32'(mem_wb_out.ctrl.reg_write), 32'd1);
    checkOutput("add_wb_ld",   mem_wb_out.load_data, 32'h0);

    // LW timeout after four wait cycles
    applyStimulus(32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1);
    tick();
    dmem_ready = 1'b0;
    #1;
    checkOutput("to_w1_berr", 32'(bus_error), 32'd0);
    checkOutput("to_w1_stall", 32'(stall_mem), 32'd1);
    tick();
    tick();
    checkOutput("to_w3_berr", 32'(bus_error), 32'd0);
    tick();
    checkOutput("to_w4_berr",  32'(bus_error), 32'd1);
    checkOutput("to_w4_stall", 32'(stall_mem), 32'd0);
    tick();
    checkOutput("to_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd1);
    checkOutput("to_wb_rw",    32'(mem_wb_out.ctrl.reg_write), 32'd0);
    checkOutput("to_berr_off", 32'(bus_error), 32'd0);
    applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    #1;
    checkOutput("late_stall", 32'(stall_mem), 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("late_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd0);
    checkOutput("late_wb_ld",    mem_wb_out.load_data, 32'h0);

    // Reset while a load is outstanding
    dmem_ready = 1'b1;
    applyStimulus(32'h400, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1);
    tick();
    dmem_ready = 1'b0;
    #1;
    checkOutput("rst_pre_stall", 32'(stall_mem), 32'd1);
    checkOutput("rst_pre_req",   32'(dmem_req), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("rst_stall",    32'(stall_mem), 32'd0);
    checkOutput("rst_wb_valid", 32'(mem_wb_out.valid_mem_wb), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst_idle_req", 32'(dmem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
